// File: rtl/pi_lane_stream_inv.sv
// Lane-serial Keccak Pi permutation engine: buffers 25 lanes of a state,
// then re-emits them in inverse (default) or forward Pi order.
module pi_lane_stream_inv #(
  parameter int W       = 64,
  parameter bit INVERSE = 1'b1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         err
);

  typedef enum logic {LOAD, DRAIN} state_t;

  localparam logic [4:0] LAST_IDX = 5'd24;

  state_t       state, state_d;
  logic [4:0]   in_cnt, in_cnt_d;
  logic [4:0]   out_cnt, out_cnt_d;
  logic         err_d;
  logic         wr_en;
  logic [W-1:0] lanes [25];
  logic [4:0]   src_tbl [25];

  // Source lane for output lane k, lane index L = 5*x + y.
  function automatic logic [4:0] src_of(input int unsigned k);
    int unsigned a, b, s;
    a = k / 5;
    b = k % 5;
    if (INVERSE) s = 5 * b + ((2 * a + 3 * b) % 5);
    else         s = 5 * ((a + 3 * b) % 5) + a;
    return 5'(s);
  endfunction

  for (genvar k = 0; k < 25; k++) begin : g_src
    assign src_tbl[k] = src_of(k);
  end

  // State and counter registers; reset aborts any frame in progress.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= LOAD;
      in_cnt  <= '0;
      out_cnt <= '0;
      err     <= 1'b0;
    end else begin
      state   <= state_d;
      in_cnt  <= in_cnt_d;
      out_cnt <= out_cnt_d;
      err     <= err_d;
    end
  end

  // Lane buffer write; contents are left as-is on reset or framing error.
  always_ff @(posedge clk) begin
    if (wr_en) lanes[in_cnt] <= in_data;
  end

  // Next-state, counter and handshake decode from registered state only.
  always_comb begin
    state_d   = state;
    in_cnt_d  = in_cnt;
    out_cnt_d = out_cnt;
    err_d     = 1'b0;
    wr_en     = 1'b0;
    in_ready  = (state == LOAD) && !rst;
    out_valid = (state == DRAIN) && !rst;
    out_last  = out_valid && (out_cnt == LAST_IDX);
    out_data  = lanes[src_tbl[out_cnt]];
    case (state)
      LOAD: begin
        if (in_valid && in_ready) begin
          if (in_last != (in_cnt == LAST_IDX)) begin
            // Mis-framed lane is dropped and the partial frame discarded.
            err_d    = 1'b1;
            in_cnt_d = '0;
          end else begin
            wr_en = 1'b1;
            if (in_cnt == LAST_IDX) begin
              in_cnt_d = '0;
              state_d  = DRAIN;
            end else begin
              in_cnt_d = in_cnt + 5'd1;
            end
          end
        end
      end
      DRAIN: begin
        if (out_ready && !rst) begin
          if (out_cnt == LAST_IDX) begin
            out_cnt_d = '0;
            state_d   = LOAD;
          end else begin
            out_cnt_d = out_cnt + 5'd1;
          end
        end
      end
      default: state_d = LOAD;
    endcase
  end

endmodule
